// File: rtl/bsel_mem_pipe.sv
// rtl/bsel_mem_pipe.sv - byte-lane writable scratch RAM with clear sequencer and pipelined read
//
// Optional feature macro: BSEL_MEM_WR_BYPASS_EN (same-address read/write returns write-first data).
//
// Ports:
//   clk, arst_n          clock (rising edge), asynchronous active-low reset
//   clr_req              one-cycle pulse starting a full zero-fill of the array
//   init_busy            high while the zero-fill runs
//   rd_en/rd_addr        read request; rd_ready accepts it
//   rd_data/rd_valid     read result, valid pulses RD_LAT cycles after accept
//   wr_en/wr_addr/wr_data/wr_bsel  write request with per-byte lane enables; wr_ready accepts it
//   wr_ack               one-cycle pulse the cycle after an accepted write
module bsel_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                clr_req,
  output logic                init_busy,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_bsel,
  output logic                wr_ready,
  output logic                wr_ack
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_acc;
  logic              wr_acc;
  logic              rd_hit;
  logic              wr_hit;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] rd_word;

  // Word presented to the pipeline input at the accept edge.
  logic              s_valid;
  logic [DATA_W-1:0] s_data;

  // Ready outputs are only high in RUN, so they double as the acceptance gate.
  assign rd_acc = rd_en && rd_ready;
  assign wr_acc = wr_en && wr_ready;

  // Range check done in 64 bits so any ADDR_W compares correctly; no modulo wrap.
  assign rd_hit = (64'(rd_addr) < 64'(DEPTH));
  assign wr_hit = (64'(wr_addr) < 64'(DEPTH));
  assign rd_idx = IDX_W'(rd_addr);
  assign wr_idx = IDX_W'(wr_addr);

  // Clear sequencer: zero-fills ptr 0..DEPTH-1, one word per cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_CLEAR;
      ptr       <= '0;
      init_busy <= 1'b1;
      rd_ready  <= 1'b0;
      wr_ready  <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (ptr == LAST_IDX) begin
            state     <= S_RUN;
            ptr       <= '0;
            init_busy <= 1'b0;
            rd_ready  <= 1'b1;
            wr_ready  <= 1'b1;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        S_RUN: begin
          if (clr_req) begin
            state     <= S_CLEAR;
            ptr       <= '0;
            init_busy <= 1'b1;
            rd_ready  <= 1'b0;
            wr_ready  <= 1'b0;
          end
        end
        default: begin
          state <= S_CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Storage: the clear sequencer owns the array while in CLEAR; otherwise
  // accepted in-range writes update only the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_acc && wr_hit) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_bsel[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read word as sampled at the accept edge. Out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      rd_word = mem[rd_idx];
    end
`ifdef BSEL_MEM_WR_BYPASS_EN
    // Write-first: merge the enabled lanes of a same-cycle write to the same word.
    if (rd_hit && wr_acc && wr_hit && (wr_idx == rd_idx)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_bsel[i]) begin
          rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
`endif
  end

  // Optional middle stage for RD_LAT == 2; RD_LAT == 1 feeds the output register directly.
  generate
    if (RD_LAT == 2) begin : g_stage
      logic              p_valid;
      logic [DATA_W-1:0] p_data;

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          p_valid <= 1'b0;
          p_data  <= '0;
        end else begin
          p_valid <= rd_acc;
          if (rd_acc) begin
            p_data <= rd_word;
          end
        end
      end

      assign s_valid = p_valid;
      assign s_data  = p_data;
    end else begin : g_direct
      assign s_valid = rd_acc;
      assign s_data  = rd_word;
    end
  endgenerate

  // Output register: rd_data holds its value between reads.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      wr_ack   <= 1'b0;
    end else begin
      rd_valid <= s_valid;
      if (s_valid) begin
        rd_data <= s_data;
      end
      wr_ack <= wr_acc;
    end
  end

endmodule
